// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and
// load/store; one outstanding transaction, with a timeout on the memory response.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TimeoutData = 32'hDEADBEEF;

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;
  typedef enum logic {OwnFetch, OwnData} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          last_owner_q, last_owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        if_gnt_q, if_gnt_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_err_q, if_err_d;
  logic        d_gnt_q, d_gnt_d;
  logic        d_rvalid_q, d_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        d_err_q, d_err_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_be_q, m_be_d;

  logic        win_data, win_fetch, store_skip, timeout;
  logic        resp_en, resp_err;
  logic [31:0] resp_data;

  // On a tie the requester that did not own the previous transaction wins.
  assign win_data   = (state_q == StIdle) && d_req &&
                      (!if_req || (last_owner_q == OwnFetch));
  assign win_fetch  = (state_q == StIdle) && if_req && !win_data;
  assign store_skip = d_we && (d_be == 4'b0000);
  assign timeout    = (cnt_q == CntLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnFetch;
      last_owner_q <= OwnFetch;
      cnt_q        <= '0;
      if_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      if_err_q     <= 1'b0;
      d_gnt_q      <= 1'b0;
      d_rvalid_q   <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
      m_req_q      <= 1'b0;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      m_be_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      if_gnt_q     <= if_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      if_err_q     <= if_err_d;
      d_gnt_q      <= d_gnt_d;
      d_rvalid_q   <= d_rvalid_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
      m_req_q      <= m_req_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      m_be_q       <= m_be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (win_data) begin
          state_d = store_skip ? StResp : StReq;
        end else if (win_fetch) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (m_ready) state_d = m_we_q ? StResp : StWait;
      end
      StWait: begin
        if (m_rvalid || timeout) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cnt_d        = cnt_q;
    m_req_d      = m_req_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    m_be_d       = m_be_q;
    if_gnt_d     = 1'b0;
    d_gnt_d      = 1'b0;
    resp_en      = 1'b0;
    resp_err     = 1'b0;
    resp_data    = '0;

    unique case (state_q)
      StIdle: begin
        if (win_data) begin
          owner_d      = OwnData;
          last_owner_d = OwnData;
          d_gnt_d      = 1'b1;
          // An all-zero-enable store has nothing to write; acknowledge it directly.
          if (store_skip) begin
            resp_en = 1'b1;
          end else begin
            m_req_d   = 1'b1;
            m_we_d    = d_we;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_be_d    = d_be;
          end
        end else if (win_fetch) begin
          owner_d      = OwnFetch;
          last_owner_d = OwnFetch;
          if_gnt_d     = 1'b1;
          m_req_d      = 1'b1;
          m_we_d       = 1'b0;
          m_addr_d     = if_addr;
          m_wdata_d    = '0;
          m_be_d       = 4'b1111;
        end
      end
      StReq: begin
        if (m_ready) begin
          m_req_d = 1'b0;
          if (m_we_q) resp_en = 1'b1;
          else        cnt_d   = '0;
        end
      end
      StWait: begin
        // Data arriving in the final timeout cycle takes priority over the error.
        if (m_rvalid) begin
          resp_en   = 1'b1;
          resp_data = m_rdata;
        end else if (timeout) begin
          resp_en   = 1'b1;
          resp_err  = 1'b1;
          resp_data = TimeoutData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: ;
    endcase

    if_rvalid_d = resp_en && (owner_d == OwnFetch);
    d_rvalid_d  = resp_en && (owner_d == OwnData);
    if_rdata_d  = if_rvalid_d ? resp_data : if_rdata_q;
    d_rdata_d   = d_rvalid_d ? resp_data : d_rdata_q;
    if_err_d    = if_rvalid_d && resp_err;
    d_err_d     = d_rvalid_d && resp_err;
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign m_req     = m_req_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_be      = m_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction vector table with a response scoreboard,
// plus hand-written tie-arbitration and reset-during-WAIT sequences.
module tb_mem_port_arbiter;

  localparam int unsigned TO = 4;
  localparam logic [31:0] EchoKey = 32'h5A5A0000;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ready, m_rvalid;
  logic [31:0] m_rdata;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .if_err   (if_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_gnt    (d_gnt),
    .d_rvalid (d_rvalid),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          rdy;        // cycles m_ready is held low while m_req is up
    int          rsp;        // cycles after accept before m_rvalid (-1: never)
    logic [31:0] mdata;
    bit          exp_mreq;
    int          exp_rv_cyc; // cycle of rvalid counted from the first sampling edge
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
    bit          err;
  } sb_t;

  int  checks = 0;
  int  failures = 0;
  sb_t sb[$];

  // Memory model state
  int          rdy_dly, rsp_dly, rdy_k, rsp_k;
  bit          acc_next, rsp_active, echo;
  logic [31:0] rsp_data, cur_rdata;

  logic any_out;
  assign any_out = |{if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
                     m_req, m_we, m_addr, m_wdata, m_be};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Called once per cycle just after the sampling point; drives inputs for the next edge.
  task automatic mem_step();
    m_rvalid = 1'b0;
    if (acc_next) begin
      acc_next   = 1'b0;
      rsp_active = (rsp_dly >= 0);
      rsp_k      = 0;
    end
    if (rsp_active) begin
      if (rsp_k == rsp_dly) begin
        m_rvalid   = 1'b1;
        m_rdata    = cur_rdata;
        rsp_active = 1'b0;
      end
      rsp_k++;
    end
    m_ready = 1'b0;
    if (m_req) begin
      if (rdy_k == rdy_dly) begin
        m_ready   = 1'b1;
        acc_next  = 1'b1;
        rdy_k     = 0;
        cur_rdata = echo ? (m_addr ^ EchoKey) : rsp_data;
      end else begin
        rdy_k++;
      end
    end
  endtask

  task automatic clear_mem();
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    acc_next = 1'b0; rsp_active = 1'b0; rdy_k = 0; rsp_k = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    clear_mem();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs_zero", any_out, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input int idx);
    sb_t         e;
    int          gnt_cyc, rv_cyc;
    bit          quiet_ok, pay_ok, hold_ok, mreq_seen, port_ok;
    logic [31:0] got_rdata, exp_rdata;
    logic        got_err, exp_err;
    rdy_dly = v.rdy; rsp_dly = v.rsp; rsp_data = v.mdata; echo = 1'b0; rdy_k = 0;
    e.is_data = v.is_data; e.rdata = v.exp_rdata; e.err = v.exp_err;
    sb.push_back(e);
    if (v.is_data) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    gnt_cyc = -1; rv_cyc = -1; quiet_ok = 1; pay_ok = 1; hold_ok = 1; mreq_seen = 0;
    port_ok = 0; got_rdata = '0; got_err = 1'b0; exp_rdata = '1; exp_err = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (v.is_data ? d_gnt : if_gnt) begin
        if (gnt_cyc < 0) gnt_cyc = c;
        else quiet_ok = 0;
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      if (v.is_data ? (if_gnt || if_rvalid || if_err) : (d_gnt || d_rvalid || d_err))
        quiet_ok = 0;
      if (m_req) begin
        mreq_seen = 1;
        if (m_addr !== v.addr || m_we !== v.we || m_be !== (v.is_data ? v.be : 4'hF) ||
            (v.we && m_wdata !== v.wdata)) pay_ok = 0;
      end
      if (rv_cyc >= 0 && c == rv_cyc + 1) begin
        if ((v.is_data ? d_err : if_err) !== 1'b0 ||
            (v.is_data ? d_rdata : if_rdata) !== got_rdata) hold_ok = 0;
      end
      if (v.is_data ? d_rvalid : if_rvalid) begin
        if (rv_cyc < 0) begin
          rv_cyc    = c;
          got_rdata = v.is_data ? d_rdata : if_rdata;
          got_err   = v.is_data ? d_err : if_err;
          if (sb.size() > 0) begin
            e         = sb.pop_front();
            port_ok   = (e.is_data == v.is_data);
            exp_rdata = e.rdata;
            exp_err   = e.err;
          end
        end else begin
          quiet_ok = 0;
        end
      end
      mem_step();
      if (rv_cyc >= 0 && c >= rv_cyc + 2) break;
    end
    sb.delete();
    check($sformatf("v%0d_gnt_cycle", idx), gnt_cyc, 1);
    check($sformatf("v%0d_rvalid_cycle", idx), rv_cyc, v.exp_rv_cyc);
    check($sformatf("v%0d_rdata", idx), got_rdata, exp_rdata);
    check($sformatf("v%0d_err", idx), got_err, exp_err);
    check($sformatf("v%0d_owner", idx), port_ok, 1);
    check($sformatf("v%0d_mreq_seen", idx), mreq_seen, v.exp_mreq);
    check($sformatf("v%0d_payload_stable", idx), pay_ok, 1);
    check($sformatf("v%0d_other_port_quiet", idx), quiet_ok, 1);
    check($sformatf("v%0d_rdata_hold_err_clear", idx), hold_ok, 1);
  endtask

  // Both ports request together; ties must alternate starting with data.
  task automatic run_tie(input int ngr, input string tag);
    sb_t e;
    int  g, g_if, g_d, rv_if, rv_d, end_c;
    bit  order_ok, sb_ok, re_if, re_d;
    rdy_dly = 0; rsp_dly = 0; echo = 1'b1; rdy_k = 0;
    if_addr = 32'h100; d_addr = 32'h200; d_we = 1'b0; d_be = 4'hF; d_wdata = '0;
    if_req = 1'b1; d_req = 1'b1;
    g = 0; g_if = 0; g_d = 0; rv_if = 0; rv_d = 0; end_c = -1;
    order_ok = 1; sb_ok = 1; re_if = 0; re_d = 0;
    sb.delete();
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (re_if) begin if_req = 1'b1; re_if = 0; end
      if (re_d)  begin d_req  = 1'b1; re_d  = 0; end
      if (if_gnt && d_gnt) order_ok = 0;
      if (d_gnt) begin
        if (g % 2 != 0) order_ok = 0;
        g++; g_d++;
        d_req = 1'b0; re_d = (g < ngr);
        e.is_data = 1; e.rdata = 32'h200 ^ EchoKey; e.err = 0;
        sb.push_back(e);
      end else if (if_gnt) begin
        if (g % 2 != 1) order_ok = 0;
        g++; g_if++;
        if_req = 1'b0; re_if = (g < ngr);
        e.is_data = 0; e.rdata = 32'h100 ^ EchoKey; e.err = 0;
        sb.push_back(e);
      end
      if (g >= ngr) begin
        if_req = 1'b0; d_req = 1'b0; re_if = 0; re_d = 0;
      end
      if (d_rvalid) begin
        rv_d++;
        if (sb.size() == 0) sb_ok = 0;
        else begin
          e = sb.pop_front();
          if (!e.is_data || d_rdata !== e.rdata || d_err !== 1'b0) sb_ok = 0;
        end
      end
      if (if_rvalid) begin
        rv_if++;
        if (sb.size() == 0) sb_ok = 0;
        else begin
          e = sb.pop_front();
          if (e.is_data || if_rdata !== e.rdata || if_err !== 1'b0) sb_ok = 0;
        end
      end
      mem_step();
      if (end_c < 0 && rv_if + rv_d >= ngr) end_c = c + 3;
      if (end_c >= 0 && c >= end_c) break;
    end
    check({tag, "_grant_count"}, g, ngr);
    check({tag, "_grant_order"}, order_ok, 1);
    check({tag, "_scoreboard"}, sb_ok, 1);
    check({tag, "_data_rvalid_per_gnt"}, rv_d, g_d);
    check({tag, "_fetch_rvalid_per_gnt"}, rv_if, g_if);
    sb.delete();
  endtask

  task automatic run_reset_mid_wait();
    bit rv_seen;
    rdy_dly = 0; rsp_dly = -1; echo = 1'b0; rdy_k = 0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_be = 4'hF;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      if (d_gnt) d_req = 1'b0;
      mem_step();
    end
    check("rstwait_addr_before", m_addr, 32'h500);
    #2 reset = 1'b1;
    #1;
    check("rstwait_outputs_cleared_async", any_out, 0);
    @(posedge clk);
    @(negedge clk);
    d_req = 1'b0;
    clear_mem();
    reset = 1'b0;
    rv_seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (if_rvalid || d_rvalid || m_req) rv_seen = 1;
      mem_step();
    end
    check("rstwait_no_response_after", rv_seen, 0);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           data we addr          wdata         be     rdy rsp mdata        mreq rv rdata       err
    vecs[0] = '{0, 0, 32'h00000010, 32'h0,        4'h0, 0, 0, 32'h00500093, 1, 3, 32'h00500093, 0};
    vecs[1] = '{1, 1, 32'h00000102, 32'h00AB0000, 4'h4, 3, -1, 32'h0,       1, 5, 32'h0,        0};
    vecs[2] = '{1, 1, 32'h00000200, 32'h11111111, 4'h0, 0, -1, 32'h0,       0, 1, 32'h0,        0};
    vecs[3] = '{1, 0, 32'h00000300, 32'h0,        4'hF, 0, 4, 32'hAAAA5555, 1, 6, 32'hDEADBEEF, 1};
    vecs[4] = '{0, 0, 32'h00000014, 32'h0,        4'h0, 1, 0, 32'h11223344, 1, 4, 32'h11223344, 0};
    vecs[5] = '{1, 0, 32'h00000400, 32'h0,        4'hF, 0, 3, 32'h12345678, 1, 6, 32'h12345678, 0};
    vecs[6] = '{1, 0, 32'h00000404, 32'h0,        4'h3, 2, 1, 32'hCAFEF00D, 1, 6, 32'hCAFEF00D, 0};
    vecs[7] = '{1, 1, 32'h00000408, 32'h0000BEEF, 4'h3, 0, -1, 32'h0,       1, 2, 32'h0,        0};
    vecs[8] = '{0, 0, 32'h00000020, 32'h0,        4'h0, 0, 2, 32'h0BADF00D, 1, 5, 32'h0BADF00D, 0};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      run_txn(vecs[i], i);
      if (i == 0) check("v0_data_rdata_untouched", d_rdata, 32'h0);
    end

    do_reset();
    run_tie(3, "tie3");

    run_reset_mid_wait();
    run_tie(1, "tie_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch path and the load/store data path of the RV32I core. It grants one requester at a time using round-robin arbitration and forwards that requester's transaction to memory. It then routes the memory response back to the owner. Only one transaction is outstanding at a time, and a timeout guards against a memory that never responds.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before an error response is forced (legal range 1..65535).

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
if_req  in  1  fetch request; held until if_gnt is seen
if_addr  in  32  fetch byte address
if_gnt  out  1  one-cycle pulse: fetch request captured
if_rvalid  out  1  one-cycle pulse: fetch response valid
if_rdata  out  32  fetch read data
if_err  out  1  fetch timeout error; valid with if_rvalid
d_req  in  1  data request; held until d_gnt is seen
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  32  store data, already lane-aligned
d_be  in  4  byte enables
d_gnt  out  1  one-cycle pulse: data request captured
d_rvalid  out  1  one-cycle pulse: load data or store ack valid
d_rdata  out  32  load data (0 for store ack)
d_err  out  1  data timeout error; valid with d_rvalid
m_req  out  1  memory request valid
m_we  out  1  memory write
m_addr  out  32  memory byte address
m_wdata  out  32  memory write data
m_be  out  4  memory byte enables
m_ready  in  1  memory accepts the request when m_req and m_ready are both high at a clock edge
m_rvalid  in  1  memory read data valid
m_rdata  in  32  memory read data

Behaviour:
- Reset: clk and reset as stated above (reset asynchronous, active-high). Every output goes to 0, the state goes to IDLE, last_owner goes to FETCH, and the timeout counter goes to 0. Reset mid-transaction aborts it; no response is ever issued for the aborted transaction.
- All outputs are registered. States are IDLE, REQ, WAIT and RESP.
- IDLE: requests are sampled at each edge.
  - If only one requester is asserting, it wins.
  - If both are asserting, the winner is the one that is not last_owner, so data wins the first tie after reset.
  - On a win: latch the winner's payload into the m_* registers and set owner and last_owner. Fetch always drives m_we=0 and m_be=4'b1111.
  - Next cycle: pulse the winner's gnt and enter REQ with m_req=1.
  - Special case: a data store with d_be==0 latches nothing, goes straight to RESP, and produces no m_req.
- Requester rule: req and payload are held until gnt is seen high, then req is dropped. While not in IDLE, the arbiter ignores both req inputs.
- REQ: m_req and the payload are held stable until m_ready is sampled high. Then m_req drops next cycle.
  - Store: go to RESP (write ack, rdata=0).
  - Load: go to WAIT and clear the counter.
- WAIT: the counter increments each cycle.
  - m_rvalid=1: capture m_rdata and go to RESP with err=0.
  - Counter reaches TIMEOUT_CYCLES without m_rvalid: go to RESP with err=1 and rdata=32'hDEADBEEF.
  - m_rvalid arriving in the same cycle as the timeout: the data wins and err=0.
- RESP: exactly one cycle. The owner's rvalid=1 with rdata and err valid; the other requester's rvalid stays 0. Next state is IDLE. After the pulse, rdata holds its value and err returns to 0.
- m_rvalid outside WAIT (including a stale response after a timeout) is ignored.
- Zero-wait-state latency: req sampled at edge 0, gnt and m_req in cycle 1, accept at the end of cycle 1, m_rvalid in cycle 2, rvalid in cycle 3, back in IDLE in cycle 4. Throughput is at most one transaction per 4 cycles.
- The counter width is enough to hold TIMEOUT_CYCLES and never wraps.

Test Plan:
1. Fetch: if_req with if_addr=0x10, m_ready=1, m_rvalid=1 with 0x00500093 one cycle after accept -> if_gnt in cycle 1; m_addr=0x10 and m_be=1111; if_rvalid in cycle 3 with if_rdata=0x00500093 and if_err=0; all d_* outputs stay 0.
2. Tie arbitration: if_req and d_req asserted together right after reset and re-asserted after each gnt -> grant order is data, fetch, data; each requester gets exactly one rvalid per grant.
3. Byte store: d_we=1, d_addr=0x102, d_wdata=0x00AB0000, d_be=0100, m_ready low for 3 cycles -> m_req and payload stable for 4 cycles; d_rvalid one cycle after accept with d_rdata=0 and d_err=0. A store with d_be=0000 -> d_rvalid with no m_req.
4. Timeout: TIMEOUT_CYCLES=4, memory never responds -> d_rvalid with d_err=1 and d_rdata=0xDEADBEEF after 4 WAIT cycles. A late m_rvalid is ignored, and the next fetch completes normally.
5. Race: m_rvalid carrying 0x12345678 in the final timeout cycle -> rvalid with rdata=0x12345678 and err=0.
6. Reset asserted during WAIT -> all outputs 0 immediately and no rvalid after release. A subsequent tie goes to data.
